param_arbiter: RTL and testbench
================================

# param_arbiter

Round-robin arbiter sharing the MIDI parameter RAM's read-only port B (7-bit word address, 16-bit data) between several synthesis-side requesters (voice engines, envelope and LFO units). It sits between the requesters and the port-B address and data pins of the parameter RAM inside the MIDI block. It issues at most one read per cycle and returns each word to the requester that asked for it after a fixed latency. Port A (CPU writes) is not touched.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- ADDR_WIDTH, default 7: port-B word address width.
- DATA_WIDTH, default 16: port-B data width.

- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  NUM_REQ  request i is pending.
- req_addr  in  NUM_REQ*ADDR_WIDTH  request i address, in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant, combinational, same cycle.
- rsp_valid  out  NUM_REQ  one-hot registered response strobe.
- rsp_data  out  DATA_WIDTH  registered read data, shared by all requesters.
- ram_addr_b  out  ADDR_WIDTH  to RAM port B address.
- ram_q_b  in  DATA_WIDTH  from RAM port B; holds data for the address sampled at the previous edge.

## Operation
- Handshake: a request transfers in a cycle where req_valid[i] and req_ready[i] are both 1.
  - The requester holds valid and addr stable until then.
  - It may change addr or drop valid in the cycle after the transfer.
- Grant is combinational from req_valid and the priority pointer `ptr` (0..NUM_REQ-1).
  - Search order is ptr, ptr+1, … wrapping modulo NUM_REQ; the first valid index wins.
  - At most one req_ready bit is high; all are 0 when no req_valid is set.
- On a transfer to index g:
  - ptr becomes (g+1) mod NUM_REQ.
  - last_addr becomes req_addr[g].
- With no transfer, ptr and last_addr hold.
- ram_addr_b equals req_addr[g] in a grant cycle; otherwise it equals last_addr, so the RAM address does not toggle when idle.
- Two-stage pipeline:
  - Stage 1 registers the one-hot grant as `pend`.
  - Stage 2 registers rsp_valid <= pend and rsp_data <= ram_q_b.
- rsp_data updates only when pend is non-zero; otherwise it holds.
- No state machine beyond the pointer and pipeline. No requester can be starved: a requester that holds valid is granted within NUM_REQ cycles.
- Read during a port-A write to the same address returns whatever the RAM gives. The arbiter does not compensate.

## Timing
- Reset values: ptr=0, last_addr=0, pend=0, rsp_valid=0, rsp_data=0. req_ready follows req_valid combinationally even while rst is high.
- rst asserted mid-operation:
  - All in-flight reads are discarded; no rsp_valid fires for them.
  - Grants made in the reset cycle are lost. Requesters must re-issue after reset.
- Latency: transfer in cycle N gives rsp_valid[g]=1 and rsp_data valid in cycle N+2, for exactly one cycle.
- Throughput: one transfer per cycle, sustained. Back-to-back responses may go to different requesters on consecutive cycles.
- The same requester may transfer on consecutive cycles only if no other requester is valid.

## Configuration
- PARAM_ARB_FIXED_PRIORITY_EN
  - Defined: fixed priority; the lowest valid index always wins. ptr is not implemented and is treated as 0. Starvation is possible and is the caller's responsibility.
  - Undefined (default): round-robin as described above.
  - Latency, handshake and reset behaviour are identical in both modes.

## Test plan
- Reset then idle: all outputs 0; ram_addr_b=0 for 10 cycles with no requests.
- Single request: preload RAM[0x15]=0xBEEF; req 2 at addr 0x15 transfers in cycle N -> rsp_valid=4'b0100 and rsp_data=0xBEEF in N+2; ram_addr_b stays 0x15 afterwards.
- Round-robin: all four requesters held valid with addrs 0x10..0x13 (RAM[a]=a) -> grant order 0,1,2,3,0 and responses 0x0010..0x0013 arriving in order, one per cycle.
- Contention: req 1 and req 3 both valid after a grant to 1 -> 3 is granted first, then 1.
  - With PARAM_ARB_FIXED_PRIORITY_EN defined, the same stimulus grants 1 every cycle.
- Reset mid-flight: grant in cycle N, rst high in N+1 -> no rsp_valid in N+2; ptr=0 afterwards.
- Wrap and hold: back-to-back reads of addr 0x7F then 0x00 -> correct data both cycles; rsp_data holds 0x00-word data while idle.

Source files
------------

// File: rtl/param_arbiter_if.sv
// param_arbiter_if: requester-side bundle of the parameter RAM port-B arbiter.
// Carries per-requester valid/addr/ready and the shared registered response.
interface param_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/param_arbiter.sv
// param_arbiter: round-robin arbiter sharing parameter RAM port B reads.
// Define PARAM_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority.
module param_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    param_arbiter_if.slave        bus,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
    logic [PW-1:0]         base;
    logic [PW:0]           sum;
    logic [PW-1:0]         idx;
    logic [PW-1:0]         gnt_idx;
    logic [NUM_REQ-1:0]    grant;
    logic                  found;
    logic                  xfer;

    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [NUM_REQ-1:0]    pend_q, pend_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign addr_a[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Search upward from base with wrap; the first valid requester wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, base} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ)) begin
                sum = sum - (PW+1)'(NUM_REQ);
            end
            idx = sum[PW-1:0];
            if (!found && bus.req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (found) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign xfer          = found;
    assign bus.req_ready = grant;

`ifdef PARAM_ARB_FIXED_PRIORITY_EN
    assign base = '0;
`else
    logic [PW-1:0] ptr_q, ptr_d;

    // Move priority to just past the requester that won this cycle.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            if (gnt_idx == PW'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign base = ptr_q;
`endif

    // Keep the RAM address parked on the last granted address when idle.
    always_comb begin
        last_addr_d = last_addr_q;
        if (xfer) begin
            last_addr_d = addr_a[gnt_idx];
        end
    end

    assign ram_addr_b = last_addr_d;

    // Grant -> pend -> response strobe; data captured only for real reads.
    always_comb begin
        pend_d      = grant;
        rsp_valid_d = pend_q;
        rsp_data_d  = rsp_data_q;
        if (|pend_q) begin
            rsp_data_d = ram_q_b;
        end
    end

    // Pipeline and parked-address registers; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr_q <= '0;
            pend_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            last_addr_q <= last_addr_d;
            pend_q      <= pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_param_arbiter.sv
// tb_param_arbiter: directed and randomized bench for param_arbiter.
// Reference model tracks priority, parked address and 2-cycle responses.
`timescale 1ns/1ps
module tb_param_arbiter;
    localparam int N  = 4;
    localparam int AW = 7;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_q_b;
    logic [DW-1:0] mem [128];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ptr      = 0;
    int last_g   = -1;

    logic [AW-1:0] m_last_addr = '0;
    logic [DW-1:0] m_held      = '0;
    logic [N-1:0]  ring_v [4];
    logic [DW-1:0] ring_d [4];
    logic          req_p  [N];
    logic [AW-1:0] req_a  [N];
    int            gl [$];

    param_arbiter_if #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) bus ();

    param_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ram_addr_b (ram_addr_b),
        .ram_q_b    (ram_q_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_q_b <= mem[ram_addr_b];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, compare DUT with the model, advance model.
    task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                        input logic r);
        int g;
        int s;
        int slot;
        logic [AW-1:0] ga;
        @(posedge clk);
        #1;
        rst           = r;
        bus.req_valid = v;
        bus.req_addr  = a;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < N; k++) begin
`ifdef PARAM_ARB_FIXED_PRIORITY_EN
            s = k;
`else
            s = (ptr + k) % N;
`endif
            if (g < 0 && v[s]) g = s;
        end
        ga = (g >= 0) ? a[g*AW +: AW] : m_last_addr;
        check("req_ready", 32'(bus.req_ready),
              (g >= 0) ? (32'd1 << g) : 32'd0);
        check("ram_addr_b", 32'(ram_addr_b), 32'(ga));
        slot = cyc % 4;
        if (ring_v[slot] != '0) m_held = ring_d[slot];
        check("rsp_valid", 32'(bus.rsp_valid), 32'(ring_v[slot]));
        check("rsp_data", 32'(bus.rsp_data), 32'(m_held));
        ring_v[slot] = '0;
        last_g = g;
        if (r) begin
            for (int i = 0; i < 4; i++) ring_v[i] = '0;
            ptr         = 0;
            m_last_addr = '0;
            m_held      = '0;
        end else if (g >= 0) begin
            ptr         = (g + 1) % N;
            m_last_addr = ga;
            ring_v[(cyc + 2) % 4] = N'(1 << g);
            ring_d[(cyc + 2) % 4] = mem[ga];
        end
        cyc++;
    endtask

    initial begin
        int exp_g;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        for (int i = 0; i < 4; i++) begin
            ring_v[i] = '0;
            ring_d[i] = '0;
        end
        for (int i = 0; i < 128; i++) mem[i] = DW'($urandom);
        mem[7'h15] = 16'hBEEF;
        for (int i = 'h10; i <= 'h13; i++) mem[i] = DW'(i);
        mem[7'h7F] = 16'h7F7F;
        mem[7'h00] = 16'hA5A5;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset then idle.
        for (int i = 0; i < 10; i++) begin
            step('0, '0, 1'b0);
            check("idle_addr", 32'(ram_addr_b), 32'h0);
        end

        // Single request from requester 2.
        step(4'b0100, {7'h00, 7'h15, 7'h00, 7'h00}, 1'b0);
        step('0, '0, 1'b0);
        check("single_park", 32'(ram_addr_b), 32'h15);
        step('0, '0, 1'b0);
        check("single_valid", 32'(bus.rsp_valid), 32'b0100);
        check("single_data", 32'(bus.rsp_data), 32'hBEEF);

        // All four held valid.
        step('0, '0, 1'b1);
        gl.delete();
        for (int i = 0; i < 5; i++) begin
            step(4'hF, {7'h13, 7'h12, 7'h11, 7'h10}, 1'b0);
            gl.push_back(last_g);
        end
        for (int i = 0; i < 5; i++) begin
`ifdef PARAM_ARB_FIXED_PRIORITY_EN
            exp_g = 0;
`else
            exp_g = i % N;
`endif
            check("rr_grant", 32'(gl[i]), 32'(exp_g));
        end
        step('0, '0, 1'b0);
`ifdef PARAM_ARB_FIXED_PRIORITY_EN
        check("rr_rsp_data", 32'(bus.rsp_data), 32'h10);
`else
        check("rr_rsp_data", 32'(bus.rsp_data), 32'h13);
`endif
        step('0, '0, 1'b0);

        // Contention between 1 and 3 after a grant to 1.
        step('0, '0, 1'b1);
        step(4'b0010, {7'h00, 7'h00, 7'h11, 7'h00}, 1'b0);
        step(4'b1010, {7'h13, 7'h00, 7'h11, 7'h00}, 1'b0);
`ifdef PARAM_ARB_FIXED_PRIORITY_EN
        check("cont_first", 32'(last_g), 32'd1);
`else
        check("cont_first", 32'(last_g), 32'd3);
`endif
        step(4'b1010, {7'h13, 7'h00, 7'h11, 7'h00}, 1'b0);
        check("cont_second", 32'(last_g), 32'd1);
        repeat (3) step('0, '0, 1'b0);

        // Reset while a read is in flight.
        step(4'b0001, {7'h00, 7'h00, 7'h00, 7'h05}, 1'b0);
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);
        check("rst_no_rsp", 32'(bus.rsp_valid), 32'h0);
        step(4'b0011, {7'h00, 7'h00, 7'h06, 7'h05}, 1'b0);
        check("rst_ptr0", 32'(last_g), 32'd0);
        repeat (3) step('0, '0, 1'b0);

        // Address wrap and data hold.
        step(4'b0001, {7'h00, 7'h00, 7'h00, 7'h7F}, 1'b0);
        step(4'b0001, {7'h00, 7'h00, 7'h00, 7'h00}, 1'b0);
        step('0, '0, 1'b0);
        check("wrap_7f", 32'(bus.rsp_data), 32'h7F7F);
        step('0, '0, 1'b0);
        check("wrap_00", 32'(bus.rsp_data), 32'hA5A5);
        repeat (3) step('0, '0, 1'b0);
        check("hold_00", 32'(bus.rsp_data), 32'hA5A5);

        // Random requesters obeying the hold-until-transfer rule.
        step('0, '0, 1'b1);
        for (int i = 0; i < N; i++) begin
            req_p[i] = 1'b0;
            req_a[i] = '0;
        end
        for (int n = 0; n < 3000; n++) begin
            logic [N-1:0]    v;
            logic [N*AW-1:0] a;
            logic            r;
            for (int i = 0; i < N; i++) begin
                if (!req_p[i] && $urandom_range(0, 2) == 0) begin
                    req_p[i] = 1'b1;
                    req_a[i] = AW'($urandom);
                end
                v[i]         = req_p[i];
                a[i*AW +: AW] = req_a[i];
            end
            r = ($urandom_range(0, 199) == 0);
            step(v, a, r);
            if (last_g >= 0) req_p[last_g] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
